// File: rtl/ped_crossing_pkg.sv
// Shared state encodings and LED half-mask helpers for the pedestrian-crossing controller.
package ped_crossing_pkg;

  // Widest LED bank the mask helpers can describe.
  localparam int unsigned MaxLedW = 64;

  typedef enum logic [2:0] {
    StInit     = 3'd0,
    StCarGo    = 3'd1,
    StCarWarn  = 3'd2,
    StPedGo    = 3'd3,
    StPedClear = 3'd4,
    StFlash    = 3'd5
  } state_e;

  function automatic logic [MaxLedW-1:0] ped_on(input int unsigned led_w);
    return (MaxLedW'(1) << (led_w / 2)) - MaxLedW'(1);
  endfunction

  function automatic logic [MaxLedW-1:0] car_on(input int unsigned led_w);
    logic [MaxLedW-1:0] all_on;
    all_on = (led_w >= MaxLedW) ? '1 : ((MaxLedW'(1) << led_w) - MaxLedW'(1));
    return all_on & ~ped_on(led_w);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_phase_timer.sv
// Cycle counter with synchronous clear and a terminal-count flag; saturates or wraps at term.
module phase_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_clear,
  input  logic             i_w_enable,
  input  logic             i_w_wrap,
  input  logic [CNT_W-1:0] i_w_term,
  output logic             o_w_done
);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_w_done = (count_q >= i_w_term);

  always_comb begin
    count_d = count_q;
    if (i_w_clear) begin
      count_d = '0;
    end else if (i_w_enable) begin
      if (o_w_done) begin
        count_d = i_w_wrap ? '0 : count_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing lamp controller: car/ped phases with minimum green, warning and clear
// blinking phases, plus a flashing service mode. All outputs are registered together.
module ped_crossing_ctrl
  import ped_crossing_pkg::*;
#(
  parameter int unsigned LED_W       = 8,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned T_GREEN_MIN = 200000000,
  parameter int unsigned T_WARN      = 100000000,
  parameter int unsigned T_PED       = 200000000,
  parameter int unsigned T_CLEAR     = 100000000,
  parameter int unsigned T_BLINK     = 25000000
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_button,
  input  logic             i_w_enable,
  output logic [LED_W-1:0] o_r_out,
  output logic [2:0]       o_r_state,
  output logic             o_r_req_pending
);

  localparam logic [CNT_W-1:0] TGreenLast = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] TWarnLast  = CNT_W'(T_WARN - 1);
  localparam logic [CNT_W-1:0] TPedLast   = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] TClearLast = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] TBlinkLast = CNT_W'(T_BLINK - 1);

  localparam logic [MaxLedW-1:0] CarFull = car_on(LED_W);
  localparam logic [MaxLedW-1:0] PedFull = ped_on(LED_W);
  localparam logic [LED_W-1:0]   CarMask = CarFull[LED_W-1:0];
  localparam logic [LED_W-1:0]   PedMask = PedFull[LED_W-1:0];

  state_e           state_q, state_d;
  logic             btn_q;
  logic             req_q, req_d;
  logic             blink_q, blink_d;
  logic [LED_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] phase_term;
  logic             phase_done, blink_tick;
  logic             state_change, btn_rise, car_lit, ped_lit;

  assign btn_rise     = i_w_button & ~btn_q;
  assign state_change = (state_d != state_q);

  always_comb begin
    phase_term = '0;
    case (state_q)
      StCarGo:    phase_term = TGreenLast;
      StCarWarn:  phase_term = TWarnLast;
      StPedGo:    phase_term = TPedLast;
      StPedClear: phase_term = TClearLast;
      default:    phase_term = '0;
    endcase
  end

  // Saturating in CAR_GO lets a late request leave on the cycle after it latches.
  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .i_w_clk    (i_w_clk),
    .i_w_reset  (i_w_reset),
    .i_w_clear  (state_change | ~i_w_enable),
    .i_w_enable (1'b1),
    .i_w_wrap   (1'b0),
    .i_w_term   (phase_term),
    .o_w_done   (phase_done)
  );

  phase_timer #(.CNT_W(CNT_W)) u_blink_timer (
    .i_w_clk    (i_w_clk),
    .i_w_reset  (i_w_reset),
    .i_w_clear  (state_change),
    .i_w_enable (1'b1),
    .i_w_wrap   (1'b1),
    .i_w_term   (TBlinkLast),
    .o_w_done   (blink_tick)
  );

  always_comb begin
    state_d = state_q;
    if (!i_w_enable) begin
      state_d = StFlash;
    end else begin
      case (state_q)
        StInit:     state_d = StCarGo;
        StCarGo:    if (req_q && phase_done) state_d = StCarWarn;
        StCarWarn:  if (phase_done) state_d = StPedGo;
        StPedGo:    if (phase_done) state_d = StPedClear;
        StPedClear: if (phase_done) state_d = StCarGo;
        StFlash:    state_d = StInit;
        default:    state_d = StInit;
      endcase
    end
  end

  // Clearing on PED_GO entry wins over a coincident button edge.
  always_comb begin
    req_d = req_q;
    if (!i_w_enable || (state_d == StPedGo && state_q != StPedGo)) begin
      req_d = 1'b0;
    end else if (btn_rise && (state_q inside {StInit, StCarGo, StCarWarn})) begin
      req_d = 1'b1;
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (state_change) begin
      blink_d = 1'b1;
    end else if (blink_tick) begin
      blink_d = ~blink_q;
    end
  end

  always_comb begin
    car_lit = (state_d == StCarGo) ||
              (((state_d == StCarWarn) || (state_d == StFlash)) && blink_d);
    ped_lit = (state_d == StPedGo) ||
              (((state_d == StPedClear) || (state_d == StFlash)) && blink_d);
    out_d   = (car_lit ? CarMask : '0) | (ped_lit ? PedMask : '0);
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state_q <= StInit;
      btn_q   <= 1'b0;
      req_q   <= 1'b0;
      blink_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= i_w_button;
      req_q   <= req_d;
      blink_q <= blink_d;
      out_q   <= out_d;
    end
  end

  assign o_r_out         = out_q;
  assign o_r_state       = state_q;
  assign o_r_req_pending = req_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with short phase timings; outputs sampled on falling edges.
module tb_ped_crossing_ctrl;

  logic       i_w_clk = 1'b0;
  logic       i_w_reset;
  logic       i_w_button;
  logic       i_w_enable;
  logic [7:0] o_r_out;
  logic [2:0] o_r_state;
  logic       o_r_req_pending;

  int n_cmp = 0;
  int n_bad = 0;

  ped_crossing_ctrl #(
    .LED_W       (8),
    .CNT_W       (32),
    .T_GREEN_MIN (10),
    .T_WARN      (4),
    .T_PED       (6),
    .T_CLEAR     (4),
    .T_BLINK     (2)
  ) u_dut (
    .i_w_clk         (i_w_clk),
    .i_w_reset       (i_w_reset),
    .i_w_button      (i_w_button),
    .i_w_enable      (i_w_enable),
    .o_r_out         (o_r_out),
    .o_r_state       (o_r_state),
    .o_r_req_pending (o_r_req_pending)
  );

  always #5 i_w_clk = ~i_w_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] out, input logic [2:0] st,
                           input logic req);
    check_eq({tag, ".out"}, 32'(o_r_out), 32'(out));
    check_eq({tag, ".state"}, 32'(o_r_state), 32'(st));
    check_eq({tag, ".req"}, 32'(o_r_req_pending), 32'(req));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_w_clk);
  endtask

  // Leaves the bench at the falling edge of CAR_GO cycle 1.
  task automatic do_reset();
    i_w_reset  = 1'b0;
    i_w_button = 1'b0;
    i_w_enable = 1'b1;
    step(2);
    check_all("reset", 8'h00, 3'd0, 1'b0);
    i_w_reset = 1'b1;
    check_all("init", 8'h00, 3'd0, 1'b0);
    step(1);
    check_all("cargo1", 8'hF0, 3'd1, 1'b0);
  endtask

  // From CAR_GO cycle >= 10: pulse the button, ends at CAR_WARN cycle 1.
  task automatic request_to_warn();
    i_w_button = 1'b1;
    step(1);
    i_w_button = 1'b0;
    check_eq("req_latch", 32'(o_r_req_pending), 32'd1);
    step(1);
    check_all("warn1", 8'hF0, 3'd2, 1'b1);
  endtask

  logic [7:0] warn_pat  [4] = '{8'hF0, 8'hF0, 8'h00, 8'h00};
  logic [7:0] clear_pat [4] = '{8'h0F, 8'h0F, 8'h00, 8'h00};
  logic [7:0] flash_pat [6] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

  initial begin
    i_w_reset  = 1'b0;
    i_w_button = 1'b0;
    i_w_enable = 1'b1;

    // Idle after reset: CAR_GO holds without a request.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(1);
      check_all("idle", 8'hF0, 3'd1, 1'b0);
    end

    // Full cycle with a request at CAR_GO cycle 3.
    do_reset();
    step(2);
    i_w_button = 1'b1;
    step(1);
    i_w_button = 1'b0;
    check_eq("req_c4", 32'(o_r_req_pending), 32'd1);
    for (int c = 4; c <= 10; c++) begin
      check_eq("cargo_min", 32'(o_r_state), 32'd1);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      check_all("warn", warn_pat[i], 3'd2, 1'b1);
      step(1);
    end
    for (int i = 0; i < 6; i++) begin
      check_all("pedgo", 8'h0F, 3'd3, 1'b0);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      check_all("pedclr", clear_pat[i], 3'd4, 1'b0);
      step(1);
    end
    check_all("back_cargo", 8'hF0, 3'd1, 1'b0);

    // Late request at CAR_GO cycle 25 -> CAR_WARN at cycle 27.
    step(24);
    check_eq("late_c25", 32'(o_r_state), 32'd1);
    i_w_button = 1'b1;
    step(1);
    i_w_button = 1'b0;
    check_all("late_c26", 8'hF0, 3'd1, 1'b1);
    step(1);
    check_all("late_c27", 8'hF0, 3'd2, 1'b1);

    // Button held high from CAR_WARN through PED_GO into CAR_GO: no new request.
    i_w_button = 1'b1;
    step(4);
    check_all("held_ped1", 8'h0F, 3'd3, 1'b0);
    step(10);
    check_all("held_cargo1", 8'hF0, 3'd1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1);
      check_all("held_cargo", 8'hF0, 3'd1, 1'b0);
    end
    i_w_button = 1'b0;
    step(1);

    // Edge on the CAR_WARN -> PED_GO cycle is dropped; then enable drop mid-PED_GO.
    request_to_warn();
    step(3);
    i_w_button = 1'b1;
    step(1);
    i_w_button = 1'b0;
    check_all("edge_at_ped", 8'h0F, 3'd3, 1'b0);
    step(2);
    i_w_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_all("flash", flash_pat[i], 3'd5, 1'b0);
    end
    i_w_enable = 1'b1;
    step(1);
    check_all("flash_init", 8'h00, 3'd0, 1'b0);
    step(1);
    check_all("flash_cargo", 8'hF0, 3'd1, 1'b0);

    // Asynchronous reset in the middle of CAR_WARN.
    step(9);
    request_to_warn();
    step(1);
    check_all("warn2", 8'hF0, 3'd2, 1'b1);
    #2 i_w_reset = 1'b0;
    #1 check_all("async_rst", 8'h00, 3'd0, 1'b0);
    step(1);
    i_w_reset = 1'b1;
    step(1);
    check_all("after_rst", 8'hF0, 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
